// File: rtl/hazard_pkg.sv
// Shared constants and types for the hazard controller.
// Holds the bypass-select encoding, the FSM state encoding and the counter width.
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_MA = 2'b01;
    localparam logic [1:0] FWD_WB = 2'b10;

    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD_WAIT = 2'd1,
        ST_FLUSH     = 2'd2
    } hz_state_t;

endpackage

// File: rtl/hazard_fwd_port.sv
// Per-source-port bypass compare and select, plus the load-use hit for that port.
// Ports: en (port live), rs, ma_rd/ma_we/ma_is_load, wb_rd/wb_we -> sel, load_hit.
module hazard_fwd_port
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              en,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] ma_rd,
    input  logic              ma_we,
    input  logic              ma_is_load,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_we
,   output logic [1:0]        sel,
    output logic              load_hit
);

    logic ma_match;
    logic wb_match;
    logic ma_fwd;

    // x0 is hardwired zero, so it never bypasses or hazards.
    assign ma_match = en && (|rs) && (rs == ma_rd) && ma_we;
    assign wb_match = en && (|rs) && (rs == wb_rd) && wb_we;
    // Load data is not ready in MA; that case is a stall, not a bypass.
    assign ma_fwd   = ma_match && !ma_is_load;
    assign load_hit = ma_match && ma_is_load;

    always_comb begin
        sel = FWD_RF;
        priority case (1'b1)
            ma_fwd:   sel = FWD_MA;
            wb_match: sel = FWD_WB;
            default:  sel = FWD_RF;
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand bypass selects, load-use stall, redirect flush.
// Ports: clk, rst (async, active-high), EX/MA/WB operand info, redirect -> fwd_sel,
// stall, bubble, flush, busy. Optional HAZARD_STATS_EN adds stall_cnt, flush_cnt,
// loaduse_cnt (32-bit saturating event counters).
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NUM_SRC     = 2,
    parameter int REG_AW      = 5,
    parameter int LOAD_LAT    = 1,
    parameter int FLUSH_DEPTH = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ex_valid,
    input  logic [NUM_SRC*REG_AW-1:0] ex_rs,
    input  logic [NUM_SRC-1:0]        ex_rs_used,
    input  logic [REG_AW-1:0]         ma_rd,
    input  logic                      ma_we,
    input  logic                      ma_is_load,
    input  logic [REG_AW-1:0]         wb_rd,
    input  logic                      wb_we,
    input  logic                      redirect,
    output logic [2*NUM_SRC-1:0]      fwd_sel,
    output logic                      stall,
    output logic                      bubble,
    output logic                      flush,
    output logic                      busy
`ifdef HAZARD_STATS_EN
,   output logic [31:0]               stall_cnt,
    output logic [31:0]               flush_cnt,
    output logic [31:0]               loaduse_cnt
`endif
);

    // The cycle spent in IDLE (or the redirect cycle) is the first of the
    // sequence, so the wait states only need LAT-1 / DEPTH-1 more cycles;
    // cnt holds the number of extra cycles after the current one.
    localparam int LW_RLD = (LOAD_LAT > 1) ? LOAD_LAT - 2 : 0;
    localparam int FL_RLD = (FLUSH_DEPTH > 1) ? FLUSH_DEPTH - 2 : 0;
    localparam logic [CNT_W-1:0] LW_RELOAD = CNT_W'(LW_RLD);
    localparam logic [CNT_W-1:0] FL_RELOAD = CNT_W'(FL_RLD);
    localparam bit LW_MULTI = (LOAD_LAT > 1);
    localparam bit FL_MULTI = (FLUSH_DEPTH > 1);

    hz_state_t        state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [NUM_SRC-1:0] hit;
    logic             load_use;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_port
        hazard_fwd_port #(
            .REG_AW(REG_AW)
        ) u_port (
            .en        (ex_valid && ex_rs_used[i] && !rst),
            .rs        (ex_rs[i*REG_AW +: REG_AW]),
            .ma_rd     (ma_rd),
            .ma_we     (ma_we),
            .ma_is_load(ma_is_load),
            .wb_rd     (wb_rd),
            .wb_we     (wb_we),
            .sel       (fwd_sel[2*i +: 2]),
            .load_hit  (hit[i])
        );
    end

    assign load_use = |hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        stall    = 1'b0;
        bubble   = 1'b0;
        flush    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (redirect) begin
                    flush = 1'b1;
                    if (FL_MULTI) begin
                        state_nx = ST_FLUSH;
                        cnt_nx   = FL_RELOAD;
                    end
                end else if (load_use) begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                    if (LW_MULTI) begin
                        state_nx = ST_LOAD_WAIT;
                        cnt_nx   = LW_RELOAD;
                    end
                end
            end
            ST_LOAD_WAIT: begin
                if (redirect) begin
                    flush = 1'b1;
                    if (FL_MULTI) begin
                        state_nx = ST_FLUSH;
                        cnt_nx   = FL_RELOAD;
                    end else begin
                        state_nx = ST_IDLE;
                        cnt_nx   = '0;
                    end
                end else begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                    if (cnt == '0) state_nx = ST_IDLE;
                    else           cnt_nx   = cnt - 1'b1;
                end
            end
            ST_FLUSH: begin
                flush = 1'b1;
                if (redirect) begin
                    if (FL_MULTI) begin
                        cnt_nx = FL_RELOAD;
                    end else begin
                        state_nx = ST_IDLE;
                        cnt_nx   = '0;
                    end
                end else if (cnt == '0) begin
                    state_nx = ST_IDLE;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase
        // Reset must silence the outputs even before the async clear settles.
        if (rst) begin
            stall  = 1'b0;
            bubble = 1'b0;
            flush  = 1'b0;
        end
    end

    assign busy = (state != ST_IDLE) && !rst;

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt   <= '0;
            flush_cnt   <= '0;
            loaduse_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 32'd1;
            if (flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 32'd1;
            if ((state == ST_IDLE) && load_use && (loaduse_cnt != '1))
                loaduse_cnt <= loaduse_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: dut_a (LOAD_LAT=3, FLUSH_DEPTH=3) and
// dut_b (LOAD_LAT=1, FLUSH_DEPTH=1) share the same input vectors.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic [9:0]  ex_rs = '0;
    logic [1:0]  ex_rs_used = '0;
    logic [4:0]  ma_rd = '0;
    logic        ma_we = 1'b0;
    logic        ma_is_load = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic        wb_we = 1'b0;
    logic        redirect = 1'b0;

    logic [3:0]  fwd_a, fwd_b;
    logic        stall_a, bubble_a, flush_a, busy_a;
    logic        stall_b, bubble_b, flush_b, busy_b;
`ifdef HAZARD_STATS_EN
    logic [31:0] sc_a, fc_a, lc_a, sc_b, fc_b, lc_b;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] fwd;
        logic [3:0] a;
        logic [3:0] b;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    hazard_ctrl #(
        .NUM_SRC(2), .REG_AW(5), .LOAD_LAT(3), .FLUSH_DEPTH(3)
    ) dut_a (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_rs(ex_rs),
        .ex_rs_used(ex_rs_used), .ma_rd(ma_rd), .ma_we(ma_we),
        .ma_is_load(ma_is_load), .wb_rd(wb_rd), .wb_we(wb_we),
        .redirect(redirect), .fwd_sel(fwd_a), .stall(stall_a),
        .bubble(bubble_a), .flush(flush_a), .busy(busy_a)
`ifdef HAZARD_STATS_EN
        , .stall_cnt(sc_a), .flush_cnt(fc_a), .loaduse_cnt(lc_a)
`endif
    );

    hazard_ctrl #(
        .NUM_SRC(2), .REG_AW(5), .LOAD_LAT(1), .FLUSH_DEPTH(1)
    ) dut_b (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_rs(ex_rs),
        .ex_rs_used(ex_rs_used), .ma_rd(ma_rd), .ma_we(ma_we),
        .ma_is_load(ma_is_load), .wb_rd(wb_rd), .wb_we(wb_we),
        .redirect(redirect), .fwd_sel(fwd_b), .stall(stall_b),
        .bubble(bubble_b), .flush(flush_b), .busy(busy_b)
`ifdef HAZARD_STATS_EN
        , .stall_cnt(sc_b), .flush_cnt(fc_b), .loaduse_cnt(lc_b)
`endif
    );

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", n, act, req, $time);
        end
    endtask

    // Monitor: one expectation per cycle, checked mid-cycle.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("fwd_a", {28'd0, fwd_a}, {28'd0, e.fwd});
            chk("fwd_b", {28'd0, fwd_b}, {28'd0, e.fwd});
            chk("ctl_a", {28'd0, stall_a, bubble_a, flush_a, busy_a},
                {28'd0, e.a});
            chk("ctl_b", {28'd0, stall_b, bubble_b, flush_b, busy_b},
                {28'd0, e.b});
        end
    end

    // ea/eb are {stall, bubble, flush, busy}.
    task automatic drv(input logic r, input logic ev,
                       input logic [4:0] rs1, input logic [4:0] rs0,
                       input logic [1:0] used,
                       input logic [4:0] mrd, input logic mwe, input logic mld,
                       input logic [4:0] wrd, input logic wwe, input logic rdr,
                       input logic [3:0] efwd, input logic [3:0] ea,
                       input logic [3:0] eb);
        exp_t e;
        @(posedge clk);
        #1;
        rst        = r;
        ex_valid   = ev;
        ex_rs      = {rs1, rs0};
        ex_rs_used = used;
        ma_rd      = mrd;
        ma_we      = mwe;
        ma_is_load = mld;
        wb_rd      = wrd;
        wb_we      = wwe;
        redirect   = rdr;
        e.fwd = efwd;
        e.a   = ea;
        e.b   = eb;
        sbq.push_back(e);
    endtask

    task automatic idle(input logic rdr, input logic [3:0] ea,
                        input logic [3:0] eb);
        drv(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, rdr, 4'b0000, ea, eb);
    endtask

    task automatic load_use(input logic rdr, input logic [3:0] ea,
                            input logic [3:0] eb);
        drv(0, 1, 0, 5, 2'b01, 5, 1, 1, 0, 0, rdr, 4'b0000, ea, eb);
    endtask

    task automatic drain(input logic rdr, input logic [3:0] ea,
                         input logic [3:0] eb);
        drv(0, 1, 0, 5, 2'b01, 0, 0, 0, 5, 1, rdr, 4'b0010, ea, eb);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset with live-looking inputs: everything quiet
        drv(1, 1, 3, 3, 2'b11, 3, 1, 0, 3, 1, 1, 4'b0000, 4'b0000, 4'b0000);
        // both ports hit MA (ALU) over WB
        drv(0, 1, 3, 3, 2'b11, 3, 1, 0, 3, 1, 0, 4'b0101, 4'b0000, 4'b0000);
        // x0 never bypasses; port1 from WB
        drv(0, 1, 7, 0, 2'b11, 0, 1, 0, 7, 1, 0, 4'b1000, 4'b0000, 4'b0000);
        // unused port masked
        drv(0, 1, 3, 3, 2'b01, 3, 1, 0, 3, 1, 0, 4'b0001, 4'b0000, 4'b0000);
        // invalid EX masks all ports
        drv(0, 0, 3, 3, 2'b11, 3, 1, 0, 3, 1, 0, 4'b0000, 4'b0000, 4'b0000);
        // MA not writing: WB only on port0
        drv(0, 1, 4, 6, 2'b11, 4, 0, 0, 6, 1, 0, 4'b0010, 4'b0000, 4'b0000);

        // load-use: A stalls 3 cycles, B stalls 1
        load_use(0, 4'b1100, 4'b1100);
        drain(0, 4'b1101, 4'b0000);
        drain(0, 4'b1101, 4'b0000);
        idle(0, 4'b0000, 4'b0000);

        // redirect in A's second stall cycle
        load_use(0, 4'b1100, 4'b1100);
        drain(1, 4'b0011, 4'b0010);
        idle(0, 4'b0011, 4'b0000);
        idle(0, 4'b0011, 4'b0000);
        idle(0, 4'b0000, 4'b0000);

        // redirect beats same-cycle load-use
        load_use(1, 4'b0010, 4'b0010);
        idle(0, 4'b0011, 4'b0000);
        // redirect while flushing reloads the count
        idle(1, 4'b0011, 4'b0010);
        idle(0, 4'b0011, 4'b0000);
`ifdef HAZARD_STATS_EN
        @(negedge clk);
        chk("stall_cnt_a", sc_a, 32'd4);
        chk("flush_cnt_a", fc_a, 32'd6);
`endif
        // reset mid-flush
        drv(1, 1, 3, 3, 2'b11, 5, 1, 1, 3, 1, 1, 4'b0000, 4'b0000, 4'b0000);
`ifdef HAZARD_STATS_EN
        @(negedge clk);
        chk("stall_cnt_rst", sc_a, 32'd0);
        chk("flush_cnt_rst", fc_a, 32'd0);
        chk("loaduse_cnt_rst", lc_a, 32'd0);
`endif
        idle(0, 4'b0000, 4'b0000);
`ifdef HAZARD_STATS_EN
        @(negedge clk);
        chk("flush_cnt_post", fc_a, 32'd0);
        chk("loaduse_cnt_post", lc_a, 32'd0);
`endif
        // first post-reset hazard behaves as from IDLE
        load_use(0, 4'b1100, 4'b1100);
        drain(0, 4'b1101, 4'b0000);
        drain(0, 4'b1101, 4'b0000);
        idle(0, 4'b0000, 4'b0000);

        repeat (2) @(posedge clk);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d left want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
